// File: rtl/seq_chunk_adder_pkg.sv
// Shared types and constants for the sequential chunked ripple adder/subtractor.
// Holds the FSM state encoding, the add/subtract mode values and a counter-width helper.
package seq_chunk_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Keeps the chunk counter at least one bit wide when there is only one chunk
    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_chunk_adder_if.sv
// Operand/result handshake bundle for seq_chunk_adder.
// The producer/consumer side uses the master modport, the adder uses slave.
interface seq_chunk_adder_if #(
    parameter int WIDTH = 16
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf
    );

endinterface

// File: rtl/seq_chunk_adder_chunk_add.sv
// Single-bit full adder and the CHUNK-bit ripple adder built from it.
// The ripple chain here is the per-cycle critical path of seq_chunk_adder.
module fulladd (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);

    assign o_s    = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

module chunk_add #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_s,
    output logic             o_cout
);

    logic [CHUNK:0] w_carry;

    assign w_carry[0] = i_cin;

    for (genvar gBit = 0; gBit < CHUNK; gBit++) begin : g_bit
        fulladd u_fa (
            .i_a    (i_a[gBit]),
            .i_b    (i_b[gBit]),
            .i_cin  (w_carry[gBit]),
            .o_s    (o_s[gBit]),
            .o_cout (w_carry[gBit+1])
        );
    end

    assign o_cout = w_carry[CHUNK];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor that pushes CHUNK bits per clock through one
// shared ripple adder, keeping the inter-chunk carry in a register.
module seq_chunk_adder
    import seq_chunk_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    seq_chunk_adder_if.slave bus
);

    localparam int                NCHUNK     = WIDTH / CHUNK;
    localparam int                CNTW       = cntWidth(NCHUNK);
    localparam logic [CNTW-1:0]   LAST_CHUNK = CNTW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0]  CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_badParams
        $fatal(1, "seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
    end

    state_t           r_state;
    state_t           w_stateNext;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_s;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic [CNTW-1:0]  r_cnt;

    logic [31:0]      w_shift;
    logic [CHUNK-1:0] w_aChunk;
    logic [CHUNK-1:0] w_bChunk;
    logic [CHUNK-1:0] w_sum;
    logic             w_chunkCout;
    logic [WIDTH-1:0] w_accNext;
    logic             w_isLast;
    logic             w_ovf;

    // Chunk select: the counter picks which CHUNK-bit slice feeds the shared adder
    assign w_shift  = 32'(r_cnt) * 32'(CHUNK);
    assign w_aChunk = CHUNK'(r_a >> w_shift);
    assign w_bChunk = CHUNK'(r_b >> w_shift);

    chunk_add #(
        .CHUNK (CHUNK)
    ) u_chunkAdd (
        .i_a    (w_aChunk),
        .i_b    (w_bChunk),
        .i_cin  (r_carry),
        .o_s    (w_sum),
        .o_cout (w_chunkCout)
    );

    assign w_accNext = (r_acc & ~(CHUNK_MASK << w_shift)) | (WIDTH'(w_sum) << w_shift);
    assign w_isLast  = (r_cnt == LAST_CHUNK);

    // r_b already holds the effective (inverted in subtract mode) operand
    assign w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[CHUNK-1] != r_a[WIDTH-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        unique case (r_state)
            IDLE:    if (bus.in_valid)  w_stateNext = RUN;
            RUN:     if (w_isLast)      w_stateNext = DONE;
            DONE:    if (bus.out_ready) w_stateNext = IDLE;
            default:                    w_stateNext = IDLE;
        endcase
    end

    // Working sum fills r_acc chunk by chunk; r_s only changes on completion so the
    // visible result stays stable between operations
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_s     <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b ^ {WIDTH{bus.sub}};
                        r_carry <= (bus.sub == MODE_SUB) ? 1'b1 : bus.cin;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_acc   <= w_accNext;
                    r_carry <= w_chunkCout;
                    r_cnt   <= r_cnt + CNTW'(1);
                    if (w_isLast) begin
                        r_s    <= w_accNext;
                        r_cout <= w_chunkCout;
                        r_ovf  <= w_ovf;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE) && !rst;
    assign bus.out_valid = (r_state == DONE);
    assign bus.s         = r_s;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed self-checking bench for seq_chunk_adder; four copies (CHUNK = 4, 1, 8, 16)
// receive identical stimulus and each is checked against hand-computed results.
module tb_seq_chunk_adder;
    import seq_chunk_adder_pkg::*;

    localparam int WIDTH = 16;
    localparam int NDUT  = 4;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic             sub;
        logic [WIDTH-1:0] s;
        logic             cout;
        logic             ovf;
    } vec_t;

    logic             clk;
    logic             rst;
    logic             inValid;
    logic             outReady;
    logic             cin;
    logic             sub;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;

    logic [NDUT-1:0]            obsValid;
    logic [NDUT-1:0]            obsReady;
    logic [NDUT-1:0]            obsCout;
    logic [NDUT-1:0]            obsOvf;
    logic [NDUT-1:0][WIDTH-1:0] obsS;

    int               nChecks;
    int               nFails;
    int               capLat [NDUT];
    logic [WIDTH-1:0] capS   [NDUT];
    logic             capC   [NDUT];
    logic             capO   [NDUT];
    logic             irBad  [NDUT];

    function automatic int chunkOf(input int i);
        case (i)
            0:       return 4;
            1:       return 1;
            2:       return 8;
            default: return 16;
        endcase
    endfunction

    function automatic int latOf(input int i);
        return WIDTH / chunkOf(i);
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int CH = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 8 : 16;

        seq_chunk_adder_if #(.WIDTH(WIDTH)) u_if ();

        assign u_if.in_valid  = inValid;
        assign u_if.a         = opA;
        assign u_if.b         = opB;
        assign u_if.cin       = cin;
        assign u_if.sub       = sub;
        assign u_if.out_ready = outReady;

        seq_chunk_adder #(
            .WIDTH (WIDTH),
            .CHUNK (CH)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (u_if)
        );

        assign obsValid[g] = u_if.out_valid;
        assign obsReady[g] = u_if.in_ready;
        assign obsCout[g]  = u_if.cout;
        assign obsOvf[g]   = u_if.ovf;
        assign obsS[g]     = u_if.s;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Issue one operation to all copies and record latency, result and in_ready misbehaviour
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic c, input logic s, input logic holdReady);
        @(negedge clk);
        opA      = a;
        opB      = b;
        cin      = c;
        sub      = s;
        inValid  = 1'b1;
        outReady = holdReady;
        for (int i = 0; i < NDUT; i++) begin
            capLat[i] = -1;
            capS[i]   = '0;
            capC[i]   = 1'b0;
            capO[i]   = 1'b0;
            irBad[i]  = 1'b0;
        end
        @(posedge clk);
        #1;
        inValid = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            if (obsReady[i]) irBad[i] = 1'b1;
        end
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NDUT; i++) begin
                if ((capLat[i] < 0 || !holdReady) && obsReady[i]) irBad[i] = 1'b1;
                if (capLat[i] < 0 && obsValid[i]) begin
                    capLat[i] = n;
                    capS[i]   = obsS[i];
                    capC[i]   = obsCout[i];
                    capO[i]   = obsOvf[i];
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NDUT; i++) begin
            nChecks += 5;
            if (obsReady[i] !== 1'b0) begin nFails++; $display("[TB] FAIL reset in_ready chunk=%0d: got %b expected 0", chunkOf(i), obsReady[i]); end
            if (obsValid[i] !== 1'b0) begin nFails++; $display("[TB] FAIL reset out_valid chunk=%0d: got %b expected 0", chunkOf(i), obsValid[i]); end
            if (obsS[i] !== 16'h0000) begin nFails++; $display("[TB] FAIL reset s chunk=%0d: got %h expected 0000", chunkOf(i), obsS[i]); end
            if (obsCout[i] !== 1'b0) begin nFails++; $display("[TB] FAIL reset cout chunk=%0d: got %b expected 0", chunkOf(i), obsCout[i]); end
            if (obsOvf[i] !== 1'b0) begin nFails++; $display("[TB] FAIL reset ovf chunk=%0d: got %b expected 0", chunkOf(i), obsOvf[i]); end
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < NDUT; i++) begin
            nChecks++;
            if (obsReady[i] !== 1'b1) begin nFails++; $display("[TB] FAIL release in_ready chunk=%0d: got %b expected 1", chunkOf(i), obsReady[i]); end
        end
    endtask

    task automatic test_add();
        vec_t v [2];
        v[0] = '{16'h1234, 16'h4321, 1'b0, MODE_ADD, 16'h5555, 1'b0, 1'b0};
        v[1] = '{16'hA5A5, 16'h5A5A, 1'b1, MODE_ADD, 16'h0000, 1'b1, 1'b0};
        for (int t = 0; t < 2; t++) begin
            applyStimulus(v[t].a, v[t].b, v[t].cin, v[t].sub, 1'b1);
            for (int i = 0; i < NDUT; i++) begin
                nChecks += 5;
                if (capLat[i] !== latOf(i)) begin nFails++; $display("[TB] FAIL add%0d latency chunk=%0d: got %0d expected %0d", t, chunkOf(i), capLat[i], latOf(i)); end
                if (capS[i] !== v[t].s) begin nFails++; $display("[TB] FAIL add%0d s chunk=%0d: got %h expected %h", t, chunkOf(i), capS[i], v[t].s); end
                if (capC[i] !== v[t].cout) begin nFails++; $display("[TB] FAIL add%0d cout chunk=%0d: got %b expected %b", t, chunkOf(i), capC[i], v[t].cout); end
                if (capO[i] !== v[t].ovf) begin nFails++; $display("[TB] FAIL add%0d ovf chunk=%0d: got %b expected %b", t, chunkOf(i), capO[i], v[t].ovf); end
                if (irBad[i] !== 1'b0) begin nFails++; $display("[TB] FAIL add%0d busy in_ready chunk=%0d: got 1 expected 0", t, chunkOf(i)); end
            end
        end
    endtask

    task automatic test_carry_ripple();
        vec_t v [2];
        v[0] = '{16'hFFFF, 16'h0001, 1'b0, MODE_ADD, 16'h0000, 1'b1, 1'b0};
        v[1] = '{16'hFFFF, 16'h0000, 1'b1, MODE_ADD, 16'h0000, 1'b1, 1'b0};
        for (int t = 0; t < 2; t++) begin
            applyStimulus(v[t].a, v[t].b, v[t].cin, v[t].sub, 1'b1);
            for (int i = 0; i < NDUT; i++) begin
                nChecks += 4;
                if (capLat[i] !== latOf(i)) begin nFails++; $display("[TB] FAIL ripple%0d latency chunk=%0d: got %0d expected %0d", t, chunkOf(i), capLat[i], latOf(i)); end
                if (capS[i] !== v[t].s) begin nFails++; $display("[TB] FAIL ripple%0d s chunk=%0d: got %h expected %h", t, chunkOf(i), capS[i], v[t].s); end
                if (capC[i] !== v[t].cout) begin nFails++; $display("[TB] FAIL ripple%0d cout chunk=%0d: got %b expected %b", t, chunkOf(i), capC[i], v[t].cout); end
                if (capO[i] !== v[t].ovf) begin nFails++; $display("[TB] FAIL ripple%0d ovf chunk=%0d: got %b expected %b", t, chunkOf(i), capO[i], v[t].ovf); end
            end
        end
    endtask

    task automatic test_overflow();
        vec_t v [2];
        v[0] = '{16'h7FFF, 16'h0001, 1'b0, MODE_ADD, 16'h8000, 1'b0, 1'b1};
        v[1] = '{16'h8000, 16'h0001, 1'b0, MODE_SUB, 16'h7FFF, 1'b1, 1'b1};
        for (int t = 0; t < 2; t++) begin
            applyStimulus(v[t].a, v[t].b, v[t].cin, v[t].sub, 1'b1);
            for (int i = 0; i < NDUT; i++) begin
                nChecks += 4;
                if (capLat[i] !== latOf(i)) begin nFails++; $display("[TB] FAIL ovf%0d latency chunk=%0d: got %0d expected %0d", t, chunkOf(i), capLat[i], latOf(i)); end
                if (capS[i] !== v[t].s) begin nFails++; $display("[TB] FAIL ovf%0d s chunk=%0d: got %h expected %h", t, chunkOf(i), capS[i], v[t].s); end
                if (capC[i] !== v[t].cout) begin nFails++; $display("[TB] FAIL ovf%0d cout chunk=%0d: got %b expected %b", t, chunkOf(i), capC[i], v[t].cout); end
                if (capO[i] !== v[t].ovf) begin nFails++; $display("[TB] FAIL ovf%0d ovf chunk=%0d: got %b expected %b", t, chunkOf(i), capO[i], v[t].ovf); end
            end
        end
    endtask

    task automatic test_subtract();
        vec_t v [2];
        v[0] = '{16'h0005, 16'h0007, 1'b1, MODE_SUB, 16'hFFFE, 1'b0, 1'b0};
        v[1] = '{16'h1234, 16'h1234, 1'b0, MODE_SUB, 16'h0000, 1'b1, 1'b0};
        for (int t = 0; t < 2; t++) begin
            applyStimulus(v[t].a, v[t].b, v[t].cin, v[t].sub, 1'b1);
            for (int i = 0; i < NDUT; i++) begin
                nChecks += 4;
                if (capLat[i] !== latOf(i)) begin nFails++; $display("[TB] FAIL sub%0d latency chunk=%0d: got %0d expected %0d", t, chunkOf(i), capLat[i], latOf(i)); end
                if (capS[i] !== v[t].s) begin nFails++; $display("[TB] FAIL sub%0d s chunk=%0d: got %h expected %h", t, chunkOf(i), capS[i], v[t].s); end
                if (capC[i] !== v[t].cout) begin nFails++; $display("[TB] FAIL sub%0d cout chunk=%0d: got %b expected %b", t, chunkOf(i), capC[i], v[t].cout); end
                if (capO[i] !== v[t].ovf) begin nFails++; $display("[TB] FAIL sub%0d ovf chunk=%0d: got %b expected %b", t, chunkOf(i), capO[i], v[t].ovf); end
            end
        end
    endtask

    task automatic test_backpressure();
        // 0x8001 + 0x8001 = 0x1_0002: carry out and negative+negative -> positive overflow
        applyStimulus(16'h8001, 16'h8001, 1'b0, MODE_ADD, 1'b0);
        for (int i = 0; i < NDUT; i++) begin
            nChecks += 4;
            if (capS[i] !== 16'h0002) begin nFails++; $display("[TB] FAIL bp s chunk=%0d: got %h expected 0002", chunkOf(i), capS[i]); end
            if (capC[i] !== 1'b1) begin nFails++; $display("[TB] FAIL bp cout chunk=%0d: got %b expected 1", chunkOf(i), capC[i]); end
            if (capO[i] !== 1'b1) begin nFails++; $display("[TB] FAIL bp ovf chunk=%0d: got %b expected 1", chunkOf(i), capO[i]); end
            if (irBad[i] !== 1'b0) begin nFails++; $display("[TB] FAIL bp busy in_ready chunk=%0d: got 1 expected 0", chunkOf(i)); end
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            inValid = (k % 2 == 0);
            opA     = 16'h0F0F + 16'(k);
            opB     = 16'h3003;
            sub     = k[0];
            @(posedge clk);
            #1;
            for (int i = 0; i < NDUT; i++) begin
                nChecks += 5;
                if (obsValid[i] !== 1'b1) begin nFails++; $display("[TB] FAIL bp hold out_valid chunk=%0d: got %b expected 1", chunkOf(i), obsValid[i]); end
                if (obsS[i] !== 16'h0002) begin nFails++; $display("[TB] FAIL bp hold s chunk=%0d: got %h expected 0002", chunkOf(i), obsS[i]); end
                if (obsCout[i] !== 1'b1) begin nFails++; $display("[TB] FAIL bp hold cout chunk=%0d: got %b expected 1", chunkOf(i), obsCout[i]); end
                if (obsOvf[i] !== 1'b1) begin nFails++; $display("[TB] FAIL bp hold ovf chunk=%0d: got %b expected 1", chunkOf(i), obsOvf[i]); end
                if (obsReady[i] !== 1'b0) begin nFails++; $display("[TB] FAIL bp hold in_ready chunk=%0d: got %b expected 0", chunkOf(i), obsReady[i]); end
            end
        end
        @(negedge clk);
        inValid  = 1'b0;
        outReady = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < NDUT; i++) begin
            nChecks += 2;
            if (obsValid[i] !== 1'b0) begin nFails++; $display("[TB] FAIL bp release out_valid chunk=%0d: got %b expected 0", chunkOf(i), obsValid[i]); end
            if (obsReady[i] !== 1'b1) begin nFails++; $display("[TB] FAIL bp release in_ready chunk=%0d: got %b expected 1", chunkOf(i), obsReady[i]); end
        end
        applyStimulus(16'h0100, 16'h0001, 1'b0, MODE_SUB, 1'b1);
        for (int i = 0; i < NDUT; i++) begin
            nChecks += 4;
            if (capLat[i] !== latOf(i)) begin nFails++; $display("[TB] FAIL bp next latency chunk=%0d: got %0d expected %0d", chunkOf(i), capLat[i], latOf(i)); end
            if (capS[i] !== 16'h00FF) begin nFails++; $display("[TB] FAIL bp next s chunk=%0d: got %h expected 00ff", chunkOf(i), capS[i]); end
            if (capC[i] !== 1'b1) begin nFails++; $display("[TB] FAIL bp next cout chunk=%0d: got %b expected 1", chunkOf(i), capC[i]); end
            if (capO[i] !== 1'b0) begin nFails++; $display("[TB] FAIL bp next ovf chunk=%0d: got %b expected 0", chunkOf(i), capO[i]); end
        end
    endtask

    task automatic test_reset_mid_run();
        logic staleSeen [NDUT];
        @(negedge clk);
        opA      = 16'h1111;
        opB      = 16'h2222;
        cin      = 1'b0;
        sub      = MODE_ADD;
        inValid  = 1'b1;
        outReady = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        for (int i = 0; i < NDUT; i++) begin
            nChecks += 5;
            if (obsValid[i] !== 1'b0) begin nFails++; $display("[TB] FAIL midrst out_valid chunk=%0d: got %b expected 0", chunkOf(i), obsValid[i]); end
            if (obsS[i] !== 16'h0000) begin nFails++; $display("[TB] FAIL midrst s chunk=%0d: got %h expected 0000", chunkOf(i), obsS[i]); end
            if (obsCout[i] !== 1'b0) begin nFails++; $display("[TB] FAIL midrst cout chunk=%0d: got %b expected 0", chunkOf(i), obsCout[i]); end
            if (obsOvf[i] !== 1'b0) begin nFails++; $display("[TB] FAIL midrst ovf chunk=%0d: got %b expected 0", chunkOf(i), obsOvf[i]); end
            if (obsReady[i] !== 1'b0) begin nFails++; $display("[TB] FAIL midrst in_ready chunk=%0d: got %b expected 0", chunkOf(i), obsReady[i]); end
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < NDUT; i++) begin
            staleSeen[i] = 1'b0;
            nChecks++;
            if (obsReady[i] !== 1'b1) begin nFails++; $display("[TB] FAIL midrst release in_ready chunk=%0d: got %b expected 1", chunkOf(i), obsReady[i]); end
        end
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NDUT; i++) begin
                if (obsValid[i] !== 1'b0) staleSeen[i] = 1'b1;
            end
        end
        for (int i = 0; i < NDUT; i++) begin
            nChecks++;
            if (staleSeen[i] !== 1'b0) begin nFails++; $display("[TB] FAIL midrst stale out_valid chunk=%0d: got 1 expected 0", chunkOf(i)); end
        end
        applyStimulus(16'h0F0F, 16'h00F1, 1'b0, MODE_ADD, 1'b1);
        for (int i = 0; i < NDUT; i++) begin
            nChecks += 4;
            if (capLat[i] !== latOf(i)) begin nFails++; $display("[TB] FAIL midrst fresh latency chunk=%0d: got %0d expected %0d", chunkOf(i), capLat[i], latOf(i)); end
            if (capS[i] !== 16'h1000) begin nFails++; $display("[TB] FAIL midrst fresh s chunk=%0d: got %h expected 1000", chunkOf(i), capS[i]); end
            if (capC[i] !== 1'b0) begin nFails++; $display("[TB] FAIL midrst fresh cout chunk=%0d: got %b expected 0", chunkOf(i), capC[i]); end
            if (capO[i] !== 1'b0) begin nFails++; $display("[TB] FAIL midrst fresh ovf chunk=%0d: got %b expected 0", chunkOf(i), capO[i]); end
        end
    endtask

    initial begin
        nChecks  = 0;
        nFails   = 0;
        rst      = 1'b1;
        inValid  = 1'b0;
        outReady = 1'b1;
        cin      = 1'b0;
        sub      = 1'b0;
        opA      = '0;
        opB      = '0;
        $display("[TB] seq_chunk_adder bench start");
        test_reset();
        test_add();
        test_carry_ripple();
        test_overflow();
        test_subtract();
        test_backpressure();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/seq_chunk_adder.md
# seq_chunk_adder

Parametrised multi-cycle ripple adder/subtractor. It processes a WIDTH-bit operand pair CHUNK bits per clock through one chunk-wide ripple adder built from fulladd cells, holding the carry in a register between chunks. It has valid/ready handshakes on input and output, an add/subtract mode, and a signed-overflow flag. It is the sequential successor to the fixed 4-bit combinational ripple adder, for datapaths where area matters more than latency.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operands/mode valid.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add mode only).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- s  output  WIDTH  sum/difference.
- cout  output  1  carry-out (add) / no-borrow (sub).
- ovf  output  1  two's-complement signed overflow.

## Operation
- NCHUNK = WIDTH/CHUNK.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch a, b^{WIDTH{sub}}, and carry0 = sub ? 1 : cin. Clear the chunk counter and go to RUN.
- RUN:
  - Each cycle, chunk k = cnt adds a_lat[k*CHUNK +: CHUNK] + b_lat[...] + carry_reg.
  - Write the sum into s_reg[k*CHUNK +: CHUNK]; carry_reg takes the chunk carry-out.
  - cnt increments. After chunk NCHUNK-1, go to DONE.
- DONE:
  - out_valid=1. s, cout, ovf are held stable until out_ready.
  - On out_ready, go to IDLE.
- Results:
  - cout = final carry_reg.
  - ovf = (a_msb == b_eff_msb) && (s_msb != a_msb), where b_eff is the inverted B in sub mode.
- Subtract: s = a − b mod 2^WIDTH; cin is ignored; cout=1 means no borrow (a ≥ b unsigned).
- in_ready=0 in RUN and DONE. in_valid there is ignored, and the operands are not sampled.
- No back-to-back acceptance: DONE → IDLE takes one edge before the next accept.
- out_valid=0 in IDLE and RUN. s/cout/ovf are undefined-but-stable when out_valid=0; the implementation holds the previous result.
- Reset (asynchronous, any state including mid-RUN):
  - State → IDLE; in-flight operation discarded, never reported.
  - s=0, cout=0, ovf=0, out_valid=0; internal counter and carry registers = 0.
  - in_ready=1 once rst deasserts (0 while rst high).

## Timing
- Accept edge E0: in_valid && in_ready. Chunk k is computed on edge E(k+1).
- out_valid rises after edge E(NCHUNK). Latency is NCHUNK cycles from accept, 4 for the defaults.
- DONE lasts ≥1 cycle. With out_ready held high, it is exactly 1 cycle.
- Throughput: one operation per NCHUNK+2 cycles at best.
- CHUNK=WIDTH degenerates to 1-cycle RUN; the behaviour is otherwise identical.
- Per-cycle critical path: one CHUNK-bit ripple chain plus the chunk mux.

## Structure
- Shared package (adder_pkg):
  - State encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Mode constants: MODE_ADD=0, MODE_SUB=1.
- Sub-module chunk_add: parametrised CHUNK-bit ripple adder (a, b, cin → s, cout) generated from fulladd instances; instantiated once.
- The top level holds the FSM, counter, operand/result registers, carry register and overflow logic.
- Elaboration check: WIDTH % CHUNK != 0 is a fatal error.

## Test plan
All scenarios use WIDTH=16, CHUNK=4 unless stated.
1. Add: a=0x1234, b=0x4321, cin=0 → s=0x5555, cout=0, ovf=0; out_valid exactly 4 cycles after the accept edge; in_ready=0 throughout.
2. Full carry ripple across all chunks: a=0xFFFF, b=0x0001, cin=0 → s=0x0000, cout=1, ovf=0. Also a=0xFFFF, b=0x0000, cin=1 gives the same result.
3. Signed overflow:
   - Add: a=0x7FFF, b=0x0001 → s=0x8000, cout=0, ovf=1.
   - Sub: a=0x8000, b=0x0001 → s=0x7FFF, cout=1, ovf=1.
4. Subtract with borrow: a=0x0005, b=0x0007, sub=1, cin=1 (cin ignored) → s=0xFFFE, cout=0, ovf=0.
5. Backpressure: out_ready low for 3 cycles in DONE, with in_valid toggling and new a/b applied.
   - s/cout/ovf stay stable; in_ready stays 0; the new operands are not taken.
   - After the out_ready handshake, the next op accepts and computes correctly.
6. Reset and parameter sweep:
   - rst pulsed mid-RUN (after the 2nd chunk) → immediately out_valid=0, s=0; no stale result ever appears.
   - After release, in_ready=1 and a fresh op returns the correct result.
   - Repeat scenarios 1–4 for CHUNK=1, 8 and 16.
